// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// The DMEM_BYTE_ENABLE_EN macro switches is_misaligned to byte-strobe alignment rules.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_BUSY,
    DMEM_RESP
  } dmem_state_e;

  localparam int WORD_W   = 32;
  localparam int DBG_IDX0 = 2;
  localparam int DBG_IDX1 = 3;
  localparam int DBG_IDX2 = 4;
  localparam int DBG_IDX3 = 5;

  // Only the two low address bits matter for alignment; loads pass be=4'hF.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb, input logic [3:0] be);
`ifdef DMEM_BYTE_ENABLE_EN
    case (be)
      4'b1111:          is_misaligned = (addr_lsb != 2'b00);
      4'b0011, 4'b1100: is_misaligned = addr_lsb[0];
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: is_misaligned = 1'b0;
      default:          is_misaligned = 1'b1;
    endcase
`else
    is_misaligned = (addr_lsb != 2'b00) && (be != 4'h0);
`endif
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory: byte-laned synchronous write, asynchronous read,
// four fixed debug taps, and a full clear on reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [3:0]        i_wbe,
  input  logic [IW-1:0]     i_ridx,
  output logic [WORD_W-1:0] o_rdata,
  output logic [WORD_W-1:0] o_dbg0,
  output logic [WORD_W-1:0] o_dbg1,
  output logic [WORD_W-1:0] o_dbg2,
  output logic [WORD_W-1:0] o_dbg3
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wbe[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];
  assign o_dbg0  = r_mem[DBG_IDX0];
  assign o_dbg1  = r_mem[DBG_IDX1];
  assign o_dbg2  = r_mem[DBG_IDX2];
  assign o_dbg3  = r_mem[DBG_IDX3];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed access latency, one-cycle response pulse.
// Define DMEM_BYTE_ENABLE_EN to add the req_be byte-strobe input for partial stores.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_stall,
  output logic [WORD_W-1:0] dbg_mem8,
  output logic [WORD_W-1:0] dbg_mem12,
  output logic [WORD_W-1:0] dbg_mem16,
  output logic [WORD_W-1:0] dbg_mem20
);

  localparam int         IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e       r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_err;
  logic [IW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic [3:0]        r_be;

  logic [3:0]        w_reqBe;
  logic              w_reqErr;
  logic [IW-1:0]     w_reqIdx;
  logic [IW-1:0]     w_rdIdx;
  logic [WORD_W-1:0] w_rdData;
  logic [WORD_W-1:0] w_respData;
  logic              w_we;

`ifdef DMEM_BYTE_ENABLE_EN
  assign w_reqBe = req_write ? req_be : 4'hF;
`else
  assign w_reqBe = 4'hF;
`endif

  assign w_reqIdx  = req_addr[IW+1:2];
  assign w_reqErr  = is_misaligned(req_addr[1:0], w_reqBe) ||
                     (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_we      = (r_state == DMEM_RESP) && r_write && !r_err;
  assign mem_stall = req_valid & ~resp_valid;

  // With LATENCY=1 the response is built straight from the live request, so the read port follows it in IDLE.
  always_comb begin
    w_rdIdx    = r_idx;
    w_respData = '0;
    if (r_state == DMEM_IDLE) begin
      w_rdIdx = w_reqIdx;
      if (!w_reqErr) w_respData = req_write ? req_wdata : w_rdData;
    end else if (!r_err) begin
      w_respData = r_write ? r_wdata : w_rdData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DMEM_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (r_state)
        DMEM_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_err     <= w_reqErr;
            r_idx     <= w_reqIdx;
            r_wdata   <= req_wdata;
            r_be      <= w_reqBe;
            r_cnt     <= CNT_INIT;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state    <= DMEM_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= w_respData;
              resp_err   <= w_reqErr;
            end else begin
              r_state <= DMEM_BUSY;
            end
          end
        end
        DMEM_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state    <= DMEM_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_respData;
            resp_err   <= r_err;
          end
        end
        DMEM_RESP: begin
          r_state   <= DMEM_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= DMEM_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_wbe   (r_be),
    .i_ridx  (w_rdIdx),
    .o_rdata (w_rdData),
    .o_dbg0  (dbg_mem8),
    .o_dbg1  (dbg_mem12),
    .o_dbg2  (dbg_mem16),
    .o_dbg3  (dbg_mem20)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
// Byte-enable steps are compiled in only when DMEM_BYTE_ENABLE_EN is defined.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reqValid2, reqWrite2;
  logic [31:0] reqAddr2, reqWdata2;
  logic [3:0]  reqBe2;
  logic        ready2, respValid2, respErr2, stall2;
  logic [31:0] respRdata2, dbg8_2, dbg12_2, dbg16_2, dbg20_2;

  logic        reqValid1, reqWrite1;
  logic [31:0] reqAddr1, reqWdata1;
  logic [3:0]  reqBe1;
  logic        ready1, respValid1, respErr1, stall1;
  logic [31:0] respRdata1, dbg8_1, dbg12_1, dbg16_1, dbg20_1;

  int checkCount = 0;
  int passCount  = 0;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid2), .req_write(reqWrite2), .req_addr(reqAddr2), .req_wdata(reqWdata2),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be(reqBe2),
`endif
    .req_ready(ready2), .resp_valid(respValid2), .resp_rdata(respRdata2), .resp_err(respErr2),
    .mem_stall(stall2),
    .dbg_mem8(dbg8_2), .dbg_mem12(dbg12_2), .dbg_mem16(dbg16_2), .dbg_mem20(dbg20_2)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid1), .req_write(reqWrite1), .req_addr(reqAddr1), .req_wdata(reqWdata1),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be(reqBe1),
`endif
    .req_ready(ready1), .resp_valid(respValid1), .resp_rdata(respRdata1), .resp_err(respErr1),
    .mem_stall(stall1),
    .dbg_mem8(dbg8_1), .dbg_mem12(dbg12_1), .dbg_mem16(dbg16_1), .dbg_mem20(dbg20_1)
  );

  // Every comparison funnels through here so the pass and total counts stay in step.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Issues one request to the LATENCY=2 instance from a negedge, drops req_valid after
  // acceptance, and waits (bounded) for the response; lat=0 means no response was seen.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, output logic [31:0] rd,
                               output logic er, output int lat, output logic vAfter);
    reqWrite2 = w;
    reqAddr2  = a;
    reqWdata2 = d;
    reqBe2    = be;
    reqValid2 = 1'b1;
    @(posedge clk);
    #1 reqValid2 = 1'b0;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (respValid2) begin
        lat = i;
        rd  = respRdata2;
        er  = respErr2;
        break;
      end
    end
    @(negedge clk);
    vAfter = respValid2;
  endtask

  logic [31:0] rd;
  logic        er, vAfter, seenValid;
  int          lat;

  initial begin
    rst = 1'b0;
    reqValid2 = 0; reqWrite2 = 0; reqAddr2 = 0; reqWdata2 = 0; reqBe2 = 4'hF;
    reqValid1 = 0; reqWrite1 = 0; reqAddr1 = 0; reqWdata1 = 0; reqBe1 = 4'hF;
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("rst ready",  {31'b0, ready2},     32'd1);
    checkOutput("rst valid",  {31'b0, respValid2}, 32'd0);
    checkOutput("rst rdata",  respRdata2,          32'd0);
    checkOutput("rst err",    {31'b0, respErr2},   32'd0);
    checkOutput("rst stall",  {31'b0, stall2},     32'd0);
    checkOutput("rst dbg8",   dbg8_2,  32'd0);
    checkOutput("rst dbg12",  dbg12_2, 32'd0);
    checkOutput("rst dbg16",  dbg16_2, 32'd0);
    checkOutput("rst dbg20",  dbg20_2, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Store then load at word 2
    reqValid2 = 1'b1;
    #1 checkOutput("stall pending", {31'b0, stall2}, 32'd1);
    reqValid2 = 1'b0;
    applyStimulus(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, lat, vAfter);
    checkOutput("st8 latency",  lat, 32'd2);
    checkOutput("st8 err",      {31'b0, er}, 32'd0);
    checkOutput("st8 rdata",    rd, 32'hDEADBEEF);
    checkOutput("st8 one-shot", {31'b0, vAfter}, 32'd0);
    checkOutput("st8 dbg8",     dbg8_2, 32'hDEADBEEF);
    checkOutput("st8 ready",    {31'b0, ready2}, 32'd1);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat, vAfter);
    checkOutput("ld8 latency",  lat, 32'd2);
    checkOutput("ld8 rdata",    rd, 32'hDEADBEEF);
    checkOutput("ld8 err",      {31'b0, er}, 32'd0);

    // Error cases and the last legal word
    applyStimulus(1'b0, 32'h6, 32'h0, 4'hF, rd, er, lat, vAfter);
    checkOutput("ld6 err",      {31'b0, er}, 32'd1);
    checkOutput("ld6 rdata",    rd, 32'd0);
    applyStimulus(1'b0, 32'h100, 32'h0, 4'hF, rd, er, lat, vAfter);
    checkOutput("ld100 err",    {31'b0, er}, 32'd1);
    checkOutput("ld100 rdata",  rd, 32'd0);
    applyStimulus(1'b1, 32'h102, 32'h12345678, 4'hF, rd, er, lat, vAfter);
    checkOutput("st102 err",    {31'b0, er}, 32'd1);
    checkOutput("st102 rdata",  rd, 32'd0);
    applyStimulus(1'b1, 32'hE, 32'h0BADF00D, 4'hF, rd, er, lat, vAfter);
    checkOutput("stE err",      {31'b0, er}, 32'd1);
    checkOutput("stE dbg12",    dbg12_2, 32'd0);
    checkOutput("err dbg8",     dbg8_2,  32'hDEADBEEF);
    checkOutput("err dbg16",    dbg16_2, 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, vAfter);
    checkOutput("ld0 rdata",    rd, 32'd0);
    applyStimulus(1'b1, 32'hFC, 32'h600DCAFE, 4'hF, rd, er, lat, vAfter);
    checkOutput("stFC err",     {31'b0, er}, 32'd0);
    applyStimulus(1'b0, 32'hFC, 32'h0, 4'hF, rd, er, lat, vAfter);
    checkOutput("ldFC rdata",   rd, 32'h600DCAFE);
    checkOutput("ldFC err",     {31'b0, er}, 32'd0);
    applyStimulus(1'b0, 32'h80000008, 32'h0, 4'hF, rd, er, lat, vAfter);
    checkOutput("ldHigh err",   {31'b0, er}, 32'd1);

    // LATENCY=1 with req_valid held across two requests
    @(negedge clk);
    reqValid1 = 1'b1; reqWrite1 = 1'b1; reqAddr1 = 32'h14; reqWdata1 = 32'hCAFEF00D;
    #1 checkOutput("l1 stall pre",  {31'b0, stall1}, 32'd1);
    @(negedge clk);
    checkOutput("l1 resp1 valid", {31'b0, respValid1}, 32'd1);
    checkOutput("l1 resp1 stall", {31'b0, stall1}, 32'd0);
    checkOutput("l1 resp1 rdata", respRdata1, 32'hCAFEF00D);
    checkOutput("l1 resp1 ready", {31'b0, ready1}, 32'd0);
    reqWrite1 = 1'b0;
    @(negedge clk);
    checkOutput("l1 gap valid",   {31'b0, respValid1}, 32'd0);
    checkOutput("l1 gap stall",   {31'b0, stall1}, 32'd1);
    checkOutput("l1 gap ready",   {31'b0, ready1}, 32'd1);
    @(negedge clk);
    checkOutput("l1 resp2 valid", {31'b0, respValid1}, 32'd1);
    checkOutput("l1 resp2 rdata", respRdata1, 32'hCAFEF00D);
    checkOutput("l1 resp2 stall", {31'b0, stall1}, 32'd0);
    reqValid1 = 1'b0;
    @(negedge clk);
    checkOutput("l1 idle valid",  {31'b0, respValid1}, 32'd0);
    checkOutput("l1 idle stall",  {31'b0, stall1}, 32'd0);
    checkOutput("l1 dbg20",       dbg20_1, 32'hCAFEF00D);

`ifdef DMEM_BYTE_ENABLE_EN
    // Byte-strobe stores into word 4
    applyStimulus(1'b1, 32'h10, 32'hAABBCCDD, 4'b1111, rd, er, lat, vAfter);
    checkOutput("be full dbg16",  dbg16_2, 32'hAABBCCDD);
    applyStimulus(1'b1, 32'h11, 32'h11223344, 4'b0010, rd, er, lat, vAfter);
    checkOutput("be lane1 err",   {31'b0, er}, 32'd0);
    checkOutput("be lane1 dbg16", dbg16_2, 32'hAABB33DD);
    applyStimulus(1'b1, 32'h12, 32'hFFFFFFFF, 4'b0000, rd, er, lat, vAfter);
    checkOutput("be none err",    {31'b0, er}, 32'd0);
    checkOutput("be none dbg16",  dbg16_2, 32'hAABB33DD);
    applyStimulus(1'b1, 32'h11, 32'hFFFFFFFF, 4'b0011, rd, er, lat, vAfter);
    checkOutput("be half err",    {31'b0, er}, 32'd1);
    checkOutput("be half dbg16",  dbg16_2, 32'hAABB33DD);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat, vAfter);
    checkOutput("be load rdata",  rd, 32'hAABB33DD);
    checkOutput("be load err",    {31'b0, er}, 32'd0);
`endif

    // Reset asserted while a store to 0xC is in BUSY
    @(negedge clk);
    reqWrite2 = 1'b1; reqAddr2 = 32'hC; reqWdata2 = 32'h55AA55AA; reqBe2 = 4'hF; reqValid2 = 1'b1;
    @(posedge clk);
    #1 reqValid2 = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst ready", {31'b0, ready2}, 32'd1);
    checkOutput("midrst valid", {31'b0, respValid2}, 32'd0);
    checkOutput("midrst dbg8",  dbg8_2, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seenValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (respValid2) seenValid = 1'b1;
    end
    checkOutput("midrst no resp", {31'b0, seenValid}, 32'd0);
    checkOutput("midrst dbg12",   dbg12_2, 32'd0);
    checkOutput("midrst l1 dbg20", dbg20_1, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
